sound_mixer_ma: RTL

- Parametrised audio front end between the 8253 pulse outputs / tape I/O and the codec serializer.
- Mixes NCH one-bit pulse channels into an unsigned PCM word.
  - A box moving-average filter of depth 2^LOG2_DEPTH smooths the filtered channels.
  - Channels flagged in DIRECT_MASK bypass the filter.
- Slices ADC samples into a tape-in bit using min/max envelope tracking with slow decay and hysteresis.
- Adds over the previous generation: per-channel enables, saturation, incremental running sum and a comparator with hysteresis.

---
 rtl/sound_mixer_ma.sv | 103 ++++++++++
 1 files changed

// File: rtl/sound_mixer_ma.sv
// sound_mixer_ma: mixes gated pulse channels through a moving-average filter into PCM,
// and slices ADC samples into a tape-in bit using envelope tracking with hysteresis.
module sound_mixer_ma #(
  parameter int             NCH            = 4,
  parameter int             DECIM          = 256,
  parameter int             LOG2_DEPTH     = 2,
  parameter int             OUT_W          = 16,
  parameter logic [NCH-1:0] DIRECT_MASK    = 4'b1000,
  parameter int             ENV_DECAY_LOG2 = 16,
  parameter int             HYST           = 4
) (
  input  logic             clk18,
  input  logic             reset,
  input  logic [NCH-1:0]   pulses,
  input  logic [NCH-1:0]   ch_enable,
  input  logic             adc_strobe,
  input  logic [15:0]      adc_sample,
  output logic [OUT_W-1:0] pcm_out,
  output logic             pcm_valid,
  output logic             tapein,
  output logic [7:0]       env_low,
  output logic [7:0]       env_high
);
  localparam int CW = $clog2(NCH + 1);
  localparam int D  = 1 << LOG2_DEPTH;
  localparam int SW = CW + LOG2_DEPTH;
  localparam int FS = (OUT_W - 2 - LOG2_DEPTH - CW) < 0 ? 0 : OUT_W - 2 - LOG2_DEPTH - CW;
  localparam int MW = OUT_W + CW;
  localparam int DW = DECIM > 1 ? $clog2(DECIM) : 1;
  logic [DW-1:0]    dec;
  logic             ce, ce_d;
  logic [NCH-1:0]   a;
  logic [CW-1:0]    fc, dc, dc_r;
  logic [CW-1:0]    line [D];
  logic [SW-1:0]    sum;
  logic [MW-1:0]    mix;
  logic [OUT_W-1:0] sat;
  assign ce  = dec == '0;
  assign a   = pulses & ch_enable;
  assign mix = (MW'(sum) << FS) + (MW'(dc_r) << (OUT_W - 3));
  assign sat = |mix[MW-1:OUT_W] ? '1 : mix[OUT_W-1:0];
  always_comb begin
    fc = '0;
    dc = '0;
    for (int i = 0; i < NCH; i++) begin
      fc = fc + CW'(a[i] & ~DIRECT_MASK[i]);
      dc = dc + CW'(a[i] & DIRECT_MASK[i]);
    end
  end
  // Running sum: add the newest entry, drop the one falling off the delay line.
  always_ff @(posedge clk18 or posedge reset) begin
    if (reset) begin
      dec       <= '0;
      ce_d      <= 1'b0;
      dc_r      <= '0;
      sum       <= '0;
      pcm_out   <= '0;
      pcm_valid <= 1'b0;
      for (int i = 0; i < D; i++) line[i] <= '0;
    end else begin
      dec       <= dec == DW'(DECIM - 1) ? '0 : dec + DW'(1);
      ce_d      <= ce;
      pcm_valid <= ce_d;
      if (ce) begin
        line[0] <= fc;
        for (int i = 1; i < D; i++) line[i] <= line[i-1];
        sum  <= sum + SW'(fc) - SW'(line[D-1]);
        dc_r <= dc;
      end
      if (ce_d) pcm_out <= sat;
    end
  end
  logic [7:0]                x, level_avg, mid, low_n, high_n, thr_hi, thr_lo;
  logic [8:0]                avg_s, hi_s;
  logic [ENV_DECAY_LOG2-1:0] dcnt;
  logic                      wrap, unused_lsb;
  assign x          = adc_sample[15:8];
  assign unused_lsb = ^adc_sample[7:0];
  assign avg_s      = {1'b0, level_avg} + {1'b0, x};
  assign wrap       = &dcnt;
  assign low_n      = x < env_low ? x : wrap && env_low < level_avg ? env_low + 8'd1 : env_low;
  assign high_n     = x > env_high ? x : wrap && env_high > level_avg ? env_high - 8'd1 : env_high;
  assign hi_s       = {1'b0, mid} + 9'(HYST);
  assign thr_hi     = hi_s[8] ? 8'hFF : hi_s[7:0];
  assign thr_lo     = {1'b0, mid} < 9'(HYST) ? 8'h00 : mid - 8'(HYST);
  always_ff @(posedge clk18 or posedge reset) begin
    if (reset) begin
      level_avg <= 8'd127;
      env_low   <= 8'd127;
      env_high  <= 8'd128;
      mid       <= 8'd127;
      dcnt      <= '0;
      tapein    <= 1'b0;
    end else if (adc_strobe) begin
      level_avg <= avg_s[8:1];
      env_low   <= low_n;
      env_high  <= high_n;
      dcnt      <= dcnt + ENV_DECAY_LOG2'(1);
      mid       <= env_low + ((env_high - env_low) >> 1);
      tapein    <= x > thr_hi ? 1'b1 : x < thr_lo ? 1'b0 : tapein;
    end
  end
endmodule
